arith_dword_sequencer: RTL
==========================

# arith_dword_sequencer

Two-beat 64-bit arithmetic sequencer wrapped around the existing 32-bit `parallel_adder` in the ALU arithmetic unit. It registers a 64-bit operand pair and a select code, and generates the B-input logic word Y. It drives the adder's A/Y/Cin for the low word and then the high word, chaining the low-beat Cout into the high-beat Cin. It collects both G words into a 64-bit result with C/V/N/Z flags behind a valid/ready handshake.

## Interface
Parameters: none; widths are fixed by the 32-bit adder.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start_valid`  in  1  request present.
- `start_ready`  out  1  high only in IDLE; combinational from state.
- `A_in`  in  64  operand A.
- `B_in`  in  64  operand B.
- `S`  in  2  Y select: 00 Y=0, 01 Y=B, 10 Y=~B, 11 Y=all ones.
- `Cin_in`  in  1  carry into bit 0.
- `A`  out  32  to adder A.
- `Y`  out  32  to adder Y.
- `Cin`  out  1  to adder Cin.
- `G`  in  32  adder sum; combinational in A/Y/Cin.
- `Cout`  in  1  adder carry out.
- `result`  out  64  {high G, low G}.
- `C`, `V`, `N`, `Z`  out  1 each  carry, signed overflow, negative, zero.
- `result_valid`  out  1  result and flags valid.
- `result_ready`  in  1  consumer accepts the result.

## Operation
- Four states:
  - IDLE: `start_ready`=1. On `start_valid`, register A_in, B_in, S and Cin_in, then go to LO.
  - LO: drive A=A_reg[31:0], Y=Ylogic(B_reg[31:0],S), Cin=Cin_reg. At the edge, low result <= G, carry_reg <= Cout, then go to HI.
  - HI: drive A=A_reg[63:32], Y=Ylogic(B_reg[63:32],S), Cin=carry_reg. At the edge, high result <= G, C <= Cout, V, N, Z update, then go to DONE.
  - DONE: `result_valid`=1. On `result_ready`, go to IDLE.
- In IDLE and DONE, A, Y and Cin are driven to 0.
- Flags, computed at the HI edge:
  - V = (A_reg[63]==Y[31]) && (G[31]!=A_reg[63]), where Y is the high-beat Y word.
  - N = G[31].
  - Z = ({G, low result}==0).
- Arithmetic is modulo 2^64. The 65th bit appears only in C. S/Cin_in combinations give add, add+1, sub (S=10, Cin=1), A-B-1, transfer, increment, decrement (S=11, Cin=0).
- `result`, C, V, N and Z hold their values from the DONE edge until the next HI edge.
- Input operands are sampled only at the accept edge. Changes at any other time are ignored.

## Timing
- Reset (async) forces:
  - state to IDLE;
  - `result`, C, V, N, Z, `result_valid`, carry_reg and all operand registers to 0;
  - A, Y and Cin to 0.
- `start_ready`=1 while `reset` is high, but no request is accepted while `reset` is asserted.
- Latency: with accept at edge e, LO runs in cycle e..e+1 and HI in cycle e+1..e+2. `result_valid` rises after edge e+2.
- Throughput: at best one operation per 4 cycles. A new accept is possible at the edge after the edge that completes the DONE→IDLE handshake.
- Backpressure: `result_valid` stays high and `result` and flags stay stable for as long as `result_ready`=0. `start_valid` is ignored (start_ready=0) outside IDLE.
- `result_ready` high outside DONE has no effect.
- Reset in LO or HI aborts the operation: the partial result is discarded and nothing is emitted.
- Reset in DONE drops `result_valid` immediately, asynchronously.
- The adder is combinational. G/Cout must settle within one clock period of A/Y/Cin changing; the sequencer adds no extra wait states.

## Test plan
- A_in=0, B_in=0, S=00, Cin_in=0 → `result`=0, Z=1, C=0, V=0, N=0. `result_valid` rises exactly 2 edges after accept.
- A_in=0x0000_0000_FFFF_FFFF, B_in=1, S=01, Cin_in=0 → Cin output is 0 in LO and 1 in HI. `result`=0x0000_0001_0000_0000, C=0, Z=0.
- A_in=0xFFFF_FFFF_FFFF_FFFF, B_in=1, S=01, Cin_in=0 → `result`=0, C=1, Z=1, V=0.
- Subtract: A_in=5, B_in=7, S=10, Cin_in=1 → `result`=0xFFFF_FFFF_FFFF_FFFE, N=1, C=0, V=0. Repeat with A_in=7, B_in=5 → `result`=2, C=1.
- Overflow: A_in=0x7FFF_FFFF_FFFF_FFFF, S=00, Cin_in=1 → `result`=0x8000_0000_0000_0000, V=1, N=1, C=0.
- Handshake and reset:
  - Hold `result_ready`=0 for 5 cycles → `result_valid` and `result` stay stable, and `start_ready` stays 0 even with `start_valid` high. Raising `result_ready` → return to IDLE; the next request is accepted the following cycle.
  - Separately, assert `reset` during HI → `result_valid` never rises; state is IDLE and all outputs are 0.

Source files
------------

// File: rtl/arith_dword_sequencer_if.sv
// Request/result handshake and adder-side bus for the two-beat 64-bit
// arithmetic sequencer. The slave modport is the sequencer's view; the
// master modport is the environment (requester, consumer and adder).
interface arith_dword_sequencer_if;
  // request side
  logic        start_valid;
  logic        start_ready;
  logic [63:0] A_in;
  logic [63:0] B_in;
  logic [1:0]  S;
  logic        Cin_in;
  // adder side
  logic [31:0] A;
  logic [31:0] Y;
  logic        Cin;
  logic [31:0] G;
  logic        Cout;
  // result side
  logic [63:0] result;
  logic        C;
  logic        V;
  logic        N;
  logic        Z;
  logic        result_valid;
  logic        result_ready;

  modport slave (
    input  start_valid, A_in, B_in, S, Cin_in, G, Cout, result_ready,
    output start_ready, A, Y, Cin, result, C, V, N, Z, result_valid
  );

  modport master (
    output start_valid, A_in, B_in, S, Cin_in, G, Cout, result_ready,
    input  start_ready, A, Y, Cin, result, C, V, N, Z, result_valid
  );
endinterface

// File: rtl/arith_dword_sequencer.sv
// Two-beat 64-bit arithmetic sequencer around an external combinational
// 32-bit adder. The low word is computed in LO, the high word in HI with
// the low-beat carry chained in, and the 64-bit result plus C/V/N/Z flags
// is presented in DONE until the consumer accepts it.
module arith_dword_sequencer (
  input  logic                          clk,
  input  logic                          reset,
  arith_dword_sequencer_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_reg;

  // operands captured at the accept edge
  logic [63:0] a_reg;
  logic [63:0] b_reg;
  logic [1:0]  s_reg;
  logic        cin_reg;

  // low-beat partial result and carry; kept apart from the visible result
  // so that result only changes at the HI edge
  logic [31:0] lo_reg;
  logic        carry_reg;

  // visible result and flags
  logic [63:0] result_reg;
  logic        c_reg;
  logic        v_reg;
  logic        n_reg;
  logic        z_reg;
  logic        valid_reg;

  // registered adder drive; zero whenever the adder is not in use
  logic [31:0] a_drv_reg;
  logic [31:0] y_drv_reg;
  logic        cin_drv_reg;

  // B-input logic word: 00 zero, 01 B, 10 ~B, 11 all ones
  function automatic logic [31:0] ylogic(input logic [31:0] b, input logic [1:0] s);
    logic [31:0] y;
    case (s)
      2'b00:   y = 32'h0000_0000;
      2'b01:   y = b;
      2'b10:   y = ~b;
      default: y = 32'hFFFF_FFFF;
    endcase
    return y;
  endfunction

  // the high-beat signed overflow test uses the Y word actually driven in HI
  logic v_next;
  logic z_next;
  assign v_next = (a_reg[63] == y_drv_reg[31]) && (bus.G[31] != a_reg[63]);
  assign z_next = ({bus.G, lo_reg} == 64'd0);

  // sequencer FSM: operand capture, per-beat adder drive, result/flag update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      s_reg       <= '0;
      cin_reg     <= 1'b0;
      lo_reg      <= '0;
      carry_reg   <= 1'b0;
      result_reg  <= '0;
      c_reg       <= 1'b0;
      v_reg       <= 1'b0;
      n_reg       <= 1'b0;
      z_reg       <= 1'b0;
      valid_reg   <= 1'b0;
      a_drv_reg   <= '0;
      y_drv_reg   <= '0;
      cin_drv_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start_valid) begin
            a_reg       <= bus.A_in;
            b_reg       <= bus.B_in;
            s_reg       <= bus.S;
            cin_reg     <= bus.Cin_in;
            // preload the low-beat drive so LO sees it from its first instant
            a_drv_reg   <= bus.A_in[31:0];
            y_drv_reg   <= ylogic(bus.B_in[31:0], bus.S);
            cin_drv_reg <= bus.Cin_in;
            state_reg   <= LO;
          end
        end
        LO: begin
          lo_reg      <= bus.G;
          carry_reg   <= bus.Cout;
          // switch the adder to the high word with the low carry chained in
          a_drv_reg   <= a_reg[63:32];
          y_drv_reg   <= ylogic(b_reg[63:32], s_reg);
          cin_drv_reg <= bus.Cout;
          state_reg   <= HI;
        end
        HI: begin
          result_reg  <= {bus.G, lo_reg};
          c_reg       <= bus.Cout;
          v_reg       <= v_next;
          n_reg       <= bus.G[31];
          z_reg       <= z_next;
          valid_reg   <= 1'b1;
          a_drv_reg   <= '0;
          y_drv_reg   <= '0;
          cin_drv_reg <= 1'b0;
          state_reg   <= DONE;
        end
        DONE: begin
          if (bus.result_ready) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.start_ready  = (state_reg == IDLE);
  assign bus.A            = a_drv_reg;
  assign bus.Y            = y_drv_reg;
  assign bus.Cin          = cin_drv_reg;
  assign bus.result       = result_reg;
  assign bus.C            = c_reg;
  assign bus.V            = v_reg;
  assign bus.N            = n_reg;
  assign bus.Z            = z_reg;
  assign bus.result_valid = valid_reg;

endmodule
